sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 34 +++
 rtl/sram_ctrl_cyc_timer.sv | 28 ++
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the byte-wide SRAM controller.
`timescale 1ns/1ps
package sram_ctrl_pkg;

   // Width of the phase timer; every timing parameter must fit in it.
   localparam int CNT_W = 4;

   // Default geometry and timing.
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_PULSE_CYC = 2;
   localparam int DEF_HOLD_CYC  = 1;
   localparam int DEF_RD_CYC    = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_SETUP  = 3'd1,
      WR_PULSE  = 3'd2,
      WR_HOLD   = 3'd3,
      RD_ACCESS = 3'd4
   } state_t;

   // A phase length is legal when it is at least one cycle and fits the timer.
   function automatic bit cyc_ok(input int c);
      return (c >= 1) && (c <= (1 << CNT_W) - 1);
   endfunction

   // The timer counts down to zero, so a phase of c cycles loads c-1.
   function automatic logic [CNT_W-1:0] cyc_load(input int c);
      return CNT_W'(c - 1);
   endfunction

endpackage

// File: rtl/sram_ctrl_cyc_timer.sv
// Loadable down-counter with a zero flag; times every SRAM phase.
`timescale 1ns/1ps
module cyc_timer
   import sram_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load wins over counting; the counter parks at zero until reloaded.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous front-end for an asynchronous byte-wide SRAM: single
// read/write requests in, registered Cs_b/We_b/Oe_b strobes out.
//
// Request handshake: a request is transferred on a rising Clk edge where
// req_valid and req_ready are both high. req_ready is high only in IDLE.
// The requester holds req_we/req_addr/req_wdata stable while req_valid is
// high and may keep req_valid high across accesses; the request is taken on
// the first IDLE edge and never dropped. Completion is signalled by a
// one-cycle wr_done (write) or rsp_valid (read) pulse; there is no
// back-pressure on either.
`timescale 1ns/1ps
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC,
   parameter int RD_CYC    = DEF_RD_CYC
)(
   input  logic              Clk,
   input  logic              Rst_b,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              wr_done,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              Cs_b,
   output logic              We_b,
   output logic              Oe_b,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] IO_out,
   output logic              IO_oe,
   input  logic [DATA_W-1:0] IO_in,
   output state_t            dbg_state
);

   // Out-of-range phase lengths would wrap the 4-bit timer; refuse them.
   if (!cyc_ok(SETUP_CYC) || !cyc_ok(PULSE_CYC) ||
       !cyc_ok(HOLD_CYC)  || !cyc_ok(RD_CYC)) begin : g_bad_timing
      $error("sram_ctrl: SETUP_CYC, PULSE_CYC, HOLD_CYC and RD_CYC must be 1..15");
   end

   localparam logic [CNT_W-1:0] SETUP_LD = cyc_load(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = cyc_load(PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD  = cyc_load(HOLD_CYC);
   localparam logic [CNT_W-1:0] RD_LD    = cyc_load(RD_CYC);

   state_t           state;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;

   assign req_ready = (state == IDLE);
   assign dbg_state = state;

   // Timer reload: at acceptance and on every expiring phase that leads into
   // another timed phase. Phases that return to IDLE need no reload.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               tmr_load = 1'b1;
               tmr_val  = req_we ? SETUP_LD : RD_LD;
            end
         end
         WR_SETUP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = PULSE_LD;
            end
         end
         WR_PULSE: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   cyc_timer u_timer (
      .clk      (Clk),
      .rst_b    (Rst_b),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Access sequencer; every SRAM-side signal is a register of this block,
   // and reset releases the strobes immediately, abandoning any access.
   always_ff @(posedge Clk or negedge Rst_b) begin
      if (!Rst_b) begin
         state     <= IDLE;
         Cs_b      <= 1'b1;
         We_b      <= 1'b1;
         Oe_b      <= 1'b1;
         IO_oe     <= 1'b0;
         Address   <= '0;
         IO_out    <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  Address <= req_addr;
                  Cs_b    <= 1'b0;
                  if (req_we) begin
                     IO_out <= req_wdata;
                     IO_oe  <= 1'b1;
                     state  <= WR_SETUP;
                  end else begin
                     Oe_b  <= 1'b0;
                     state <= RD_ACCESS;
                  end
               end
            end
            WR_SETUP: begin
               if (tmr_zero) begin
                  We_b  <= 1'b0;
                  state <= WR_PULSE;
               end
            end
            WR_PULSE: begin
               if (tmr_zero) begin
                  We_b  <= 1'b1;
                  state <= WR_HOLD;
               end
            end
            WR_HOLD: begin
               if (tmr_zero) begin
                  Cs_b    <= 1'b1;
                  IO_oe   <= 1'b0;
                  wr_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            RD_ACCESS: begin
               if (tmr_zero) begin
                  rsp_rdata <= IO_in;
                  rsp_valid <= 1'b1;
                  Cs_b      <= 1'b1;
                  Oe_b      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: unit 0 uses default timing, unit 1 uses 2/3/2/4.
`timescale 1ns/1ps
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int NU = 2;
   localparam int SETUP_T [NU] = '{1, 2};
   localparam int PULSE_T [NU] = '{2, 3};
   localparam int HOLD_T  [NU] = '{1, 2};
   localparam int RD_T    [NU] = '{2, 4};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   logic          req_valid [NU];
   logic          req_ready [NU];
   logic          req_we    [NU];
   logic [AW-1:0] req_addr  [NU];
   logic [DW-1:0] req_wdata [NU];
   logic          wr_done   [NU];
   logic          rsp_valid [NU];
   logic [DW-1:0] rsp_rdata [NU];
   logic          cs_b      [NU];
   logic          we_b      [NU];
   logic          oe_b      [NU];
   logic [AW-1:0] address   [NU];
   logic [DW-1:0] io_out    [NU];
   logic          io_oe     [NU];
   logic [DW-1:0] io_in     [NU];
   state_t        dbg_state [NU];

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q [$];
   bit chk_data = 1'b1;
   int wr_done_cnt [NU];
   int rsp_cnt     [NU];
   logic          prev_cs_low [NU];
   logic [AW-1:0] prev_addr   [NU];
   logic [DW-1:0] prev_out    [NU];

   for (genvar g = 0; g < NU; g++) begin : g_unit
      logic [DW-1:0] mem [256];

      sram_ctrl #(
         .ADDR_W(AW), .DATA_W(DW),
         .SETUP_CYC(SETUP_T[g]), .PULSE_CYC(PULSE_T[g]),
         .HOLD_CYC(HOLD_T[g]), .RD_CYC(RD_T[g])
      ) dut (
         .Clk(clk), .Rst_b(rst_b),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
         .wr_done(wr_done[g]), .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
         .Cs_b(cs_b[g]), .We_b(we_b[g]), .Oe_b(oe_b[g]),
         .Address(address[g]), .IO_out(io_out[g]), .IO_oe(io_oe[g]),
         .IO_in(io_in[g]), .dbg_state(dbg_state[g])
      );

      // Asynchronous SRAM model: write lands on the rising edge of We_b.
      initial for (int i = 0; i < 256; i++) mem[i] = '0;
      always @(posedge we_b[g]) begin
         if (rst_b && !cs_b[g]) mem[address[g][7:0]] = io_out[g];
      end
      assign io_in[g] = (!cs_b[g] && !oe_b[g]) ? mem[address[g][7:0]] : '0;
   end

   // ---------------- monitor: scoreboard + invariants ----------------
   task automatic monitor();
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         for (int u = 0; u < NU; u++) begin
            checks++;
            if (!we_b[u] && !oe_b[u]) begin
               errors++; $display("FAIL inv_we_oe: unit %0d We_b=%0b Oe_b=%0b, expected not both 0", u, we_b[u], oe_b[u]);
            end
            checks++;
            if (io_oe[u] && !oe_b[u]) begin
               errors++; $display("FAIL inv_ioe_oe: unit %0d IO_oe=%0b Oe_b=%0b, expected no overlap", u, io_oe[u], oe_b[u]);
            end
            checks++;
            if (!we_b[u] && cs_b[u]) begin
               errors++; $display("FAIL inv_we_cs: unit %0d We_b=0 Cs_b=%0b, expected Cs_b=0", u, cs_b[u]);
            end
            checks++;
            if (wr_done[u] && rsp_valid[u]) begin
               errors++; $display("FAIL inv_done_rsp: unit %0d wr_done=1 rsp_valid=1, expected exclusive", u);
            end
            if (prev_cs_low[u] && !cs_b[u]) begin
               checks++;
               if (address[u] !== prev_addr[u] || io_out[u] !== prev_out[u]) begin
                  errors++; $display("FAIL inv_stable: unit %0d addr %0h out %0h, expected addr %0h out %0h",
                                     u, address[u], io_out[u], prev_addr[u], prev_out[u]);
               end
            end
            prev_cs_low[u] = !cs_b[u];
            prev_addr[u]   = address[u];
            prev_out[u]    = io_out[u];
            if (wr_done[u]) wr_done_cnt[u]++;
            if (rsp_valid[u]) begin
               rsp_cnt[u]++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL sb_unexpected: unit %0d rsp_rdata %0h with empty expected queue", u, rsp_rdata[u]);
               end else begin
                  e = exp_q.pop_front();
                  if (chk_data && rsp_rdata[u] !== e) begin
                     errors++; $display("FAIL sb_rdata: unit %0d got %0h expected %0h", u, rsp_rdata[u], e);
                  end
               end
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_accept(input int u);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[u]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL accept_timeout: unit %0d req_ready=%0b, expected 1", u, req_ready[u]);
      end
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
   endtask

   task automatic run_write(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int cs_low, output int we_low, output int we_first,
                            output int done_idx, output bit bus_ok, output bit ready_ok);
      cs_low = 0; we_low = 0; we_first = -1; done_idx = -1; bus_ok = 1'b1; ready_ok = 1'b1;
      @(posedge clk); #1;
      req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = a; req_wdata[u] = d;
      wait_accept(u);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!cs_b[u]) begin
            cs_low++;
            if (!io_oe[u] || io_out[u] !== d || address[u] !== a) bus_ok = 1'b0;
         end
         if (!we_b[u]) begin
            if (we_low == 0) we_first = i;
            we_low++;
         end
         if (wr_done[u]) begin
            done_idx = i;
            break;
         end
         if (req_ready[u]) ready_ok = 1'b0;
      end
   endtask

   task automatic run_read(input int u, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           output int cs_low, output int oe_low, output int rsp_idx,
                           output bit ioe_ok);
      cs_low = 0; oe_low = 0; rsp_idx = -1; ioe_ok = 1'b1;
      exp_q.push_back(exp_d);
      @(posedge clk); #1;
      req_valid[u] = 1'b1; req_we[u] = 1'b0; req_addr[u] = a; req_wdata[u] = '0;
      wait_accept(u);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!cs_b[u]) cs_low++;
         if (!oe_b[u]) oe_low++;
         if (io_oe[u]) ioe_ok = 1'b0;
         if (rsp_valid[u]) begin
            rsp_idx = i;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         for (int u = 0; u < NU; u++) begin
            req_valid[u] = 1'($urandom_range(0, 1));
            req_we[u]    = 1'($urandom_range(0, 1));
            req_addr[u]  = AW'($urandom_range(0, 65535));
            req_wdata[u] = DW'($urandom_range(0, 255));
         end
         @(negedge clk);
         for (int u = 0; u < NU; u++) begin
            checks++;
            if ({cs_b[u], we_b[u], oe_b[u], io_oe[u]} !== 4'b1110) begin
               errors++; $display("FAIL reset_strobes: unit %0d Cs/We/Oe/IO_oe=%b, expected 1110", u,
                                  {cs_b[u], we_b[u], oe_b[u], io_oe[u]});
            end
            checks++;
            if ({rsp_valid[u], wr_done[u]} !== 2'b00) begin
               errors++; $display("FAIL reset_pulses: unit %0d rsp_valid/wr_done=%b, expected 00", u,
                                  {rsp_valid[u], wr_done[u]});
            end
            checks++;
            if (address[u] !== '0 || io_out[u] !== '0 || rsp_rdata[u] !== '0) begin
               errors++; $display("FAIL reset_data: unit %0d addr %0h out %0h rdata %0h, expected 0", u,
                                  address[u], io_out[u], rsp_rdata[u]);
            end
         end
      end
      for (int u = 0; u < NU; u++) req_valid[u] = 1'b0;
      #2 rst_b = 1'b1;
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         checks++;
         if (req_ready[u] !== 1'b1 || dbg_state[u] !== IDLE) begin
            errors++; $display("FAIL reset_ready: unit %0d req_ready=%0b state=%0d, expected 1 / IDLE", u,
                               req_ready[u], dbg_state[u]);
         end
      end
   endtask

   task automatic test_write_default();
      int cs_low, we_low, we_first, done_idx;
      bit bus_ok, ready_ok;
      run_write(0, 16'h00A5, 8'h3C, cs_low, we_low, we_first, done_idx, bus_ok, ready_ok);
      checks++;
      if (cs_low != 4) begin errors++; $display("FAIL wr_cs_low: got %0d expected 4", cs_low); end
      checks++;
      if (we_low != 2 || we_first != 1) begin
         errors++; $display("FAIL wr_we_window: got %0d cycles from %0d, expected 2 from 1", we_low, we_first);
      end
      checks++;
      if (done_idx != 4) begin errors++; $display("FAIL wr_done_time: got %0d expected 4", done_idx); end
      checks++;
      if (!bus_ok) begin errors++; $display("FAIL wr_bus: got bus_ok=%0b expected 1", bus_ok); end
      checks++;
      if (!ready_ok) begin errors++; $display("FAIL wr_ready_low: got ready_ok=%0b expected 1", ready_ok); end
      checks++;
      if (g_unit[0].mem[8'hA5] !== 8'h3C) begin
         errors++; $display("FAIL wr_mem: got %0h expected 3c", g_unit[0].mem[8'hA5]);
      end
   endtask

   task automatic test_read_default();
      int cs_low, oe_low, rsp_idx;
      bit ioe_ok;
      run_read(0, 16'h00A5, 8'h3C, cs_low, oe_low, rsp_idx, ioe_ok);
      checks++;
      if (cs_low != 2 || oe_low != 2) begin
         errors++; $display("FAIL rd_strobes: got cs %0d oe %0d expected 2 2", cs_low, oe_low);
      end
      checks++;
      if (rsp_idx != 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", rsp_idx); end
      checks++;
      if (!ioe_ok) begin errors++; $display("FAIL rd_io_oe: got ioe_ok=%0b expected 1", ioe_ok); end
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_rdata[0] !== 8'h3C) begin errors++; $display("FAIL rd_hold: got %0h expected 3c", rsp_rdata[0]); end
   endtask

   task automatic test_back_to_back();
      bit done_seen = 1'b0;
      bit rd_acc = 1'b0;
      int gap = 0;
      int busy_ready = 0;
      int done0 = wr_done_cnt[0];
      int rsp0 = rsp_cnt[0];
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 8'h11;
      for (int i = 0; i < 64 && !req_ready[0]; i++) @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      req_we[0] = 1'b0; req_wdata[0] = '0;
      exp_q.push_back(8'h11);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (wr_done[0]) done_seen = 1'b1;
         if (done_seen && !rd_acc && cs_b[0]) gap++;
         if (!cs_b[0] && req_ready[0]) busy_ready++;
         if (rsp_valid[0]) break;
         if (done_seen && !rd_acc && req_ready[0]) begin
            rd_acc = 1'b1;
            @(posedge clk); #1;
            req_valid[0] = 1'b0;
         end
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (gap != 1) begin errors++; $display("FAIL b2b_gap: got %0d expected 1", gap); end
      checks++;
      if (busy_ready != 0) begin errors++; $display("FAIL b2b_ready: got %0d expected 0", busy_ready); end
      checks++;
      if (wr_done_cnt[0] - done0 != 1 || rsp_cnt[0] - rsp0 != 1) begin
         errors++; $display("FAIL b2b_count: got wr %0d rsp %0d expected 1 1",
                            wr_done_cnt[0] - done0, rsp_cnt[0] - rsp0);
      end
   endtask

   task automatic test_reset_mid_write();
      int done0, rsp0, cs_low, oe_low, rsp_idx;
      bit ioe_ok;
      bit in_pulse = 1'b0;
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0020; req_wdata[0] = 8'h5A;
      wait_accept(0);
      for (int i = 0; i < 32 && !in_pulse; i++) begin
         @(negedge clk);
         if (!we_b[0]) in_pulse = 1'b1;
      end
      checks++;
      if (!in_pulse) begin errors++; $display("FAIL mid_pulse_timeout: We_b=%0b expected 0", we_b[0]); end
      done0 = wr_done_cnt[0];
      #2 rst_b = 1'b0;
      #1;
      checks++;
      if ({cs_b[0], we_b[0], oe_b[0], io_oe[0]} !== 4'b1110) begin
         errors++; $display("FAIL mid_async: Cs/We/Oe/IO_oe=%b expected 1110", {cs_b[0], we_b[0], oe_b[0], io_oe[0]});
      end
      repeat (2) @(negedge clk);
      #2 rst_b = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", req_ready[0]); end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_done_cnt[0] != done0) begin
         errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", wr_done_cnt[0] - done0);
      end
      chk_data = 1'b0;
      rsp0 = rsp_cnt[0];
      run_read(0, 16'h0020, 8'h00, cs_low, oe_low, rsp_idx, ioe_ok);
      @(negedge clk);
      chk_data = 1'b1;
      checks++;
      if (rsp_idx != 2 || rsp_cnt[0] - rsp0 != 1) begin
         errors++; $display("FAIL mid_read: got latency %0d count %0d expected 2 1", rsp_idx, rsp_cnt[0] - rsp0);
      end
   endtask

   task automatic test_params();
      int cs_low, we_low, we_first, done_idx, oe_low, rsp_idx;
      bit bus_ok, ready_ok, ioe_ok;
      run_write(1, 16'h0042, 8'hC3, cs_low, we_low, we_first, done_idx, bus_ok, ready_ok);
      checks++;
      if (cs_low != 7 || done_idx != 7) begin
         errors++; $display("FAIL p_wr_cs: got cs %0d done %0d expected 7 7", cs_low, done_idx);
      end
      checks++;
      if (we_low != 3 || we_first != 2) begin
         errors++; $display("FAIL p_wr_we: got %0d from %0d expected 3 from 2", we_low, we_first);
      end
      checks++;
      if (!bus_ok || !ready_ok) begin
         errors++; $display("FAIL p_wr_bus: got bus %0b ready %0b expected 1 1", bus_ok, ready_ok);
      end
      run_read(1, 16'h0042, 8'hC3, cs_low, oe_low, rsp_idx, ioe_ok);
      checks++;
      if (rsp_idx != 4 || cs_low != 4 || oe_low != 4) begin
         errors++; $display("FAIL p_rd: got lat %0d cs %0d oe %0d expected 4 4 4", rsp_idx, cs_low, oe_low);
      end
      checks++;
      if (!ioe_ok) begin errors++; $display("FAIL p_rd_io_oe: got %0b expected 1", ioe_ok); end
   endtask

   task automatic test_random_pairs();
      int cs_low, we_low, we_first, done_idx, oe_low, rsp_idx;
      bit bus_ok, ready_ok, ioe_ok;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int k = 0; k < 6; k++) begin
         int u = k % NU;
         a = AW'($urandom_range(0, 255));
         d = DW'($urandom_range(0, 255));
         run_write(u, a, d, cs_low, we_low, we_first, done_idx, bus_ok, ready_ok);
         checks++;
         if (done_idx != SETUP_T[u] + PULSE_T[u] + HOLD_T[u] || !bus_ok) begin
            errors++; $display("FAIL rnd_write: unit %0d done %0d bus %0b expected %0d 1", u, done_idx, bus_ok,
                               SETUP_T[u] + PULSE_T[u] + HOLD_T[u]);
         end
         run_read(u, a, d, cs_low, oe_low, rsp_idx, ioe_ok);
         checks++;
         if (rsp_idx != RD_T[u]) begin
            errors++; $display("FAIL rnd_read: unit %0d latency %0d expected %0d", u, rsp_idx, RD_T[u]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int u = 0; u < NU; u++) begin
         req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0; req_wdata[u] = '0;
         wr_done_cnt[u] = 0; rsp_cnt[u] = 0;
         prev_cs_low[u] = 1'b0; prev_addr[u] = '0; prev_out[u] = '0;
      end
      rst_b = 1'b1;
      #2 rst_b = 1'b0;
      #1;
      fork
         monitor();
      join_none
      test_reset();
      test_write_default();
      test_read_default();
      test_back_to_back();
      test_reset_mid_write();
      test_params();
      test_random_pairs();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
